int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 22 ++
 rtl/int_ctrl_if.sv | 28 ++
 rtl/int_prio.sv | 28 ++
 rtl/int_ctrl.sv | 147 ++++++++++++++
 tb/tb_int_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: bus widths, default
// register addresses, FSM state encoding and a select-width helper.
package int_ctrl_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned MAX_IRQ = 8;

    localparam logic [ADDR_W-1:0] IF_ADDR_DEF = 16'hff0f;
    localparam logic [ADDR_W-1:0] IE_ADDR_DEF = 16'hffff;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // Width of a channel index; never zero so a single channel still has a select bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// CPU-side bus of the interrupt controller.
//   address/wdata/load/store : register access from the CPU
//   rdata/rsel               : combinational read data and read-select
//   intreq/intaddress/intack : interrupt request, vector and acknowledge
interface int_ctrl_if;
    import int_ctrl_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              load;
    logic              store;
    logic [DATA_W-1:0] rdata;
    logic              rsel;
    logic              intreq;
    logic [ADDR_W-1:0] intaddress;
    logic              intack;

    modport master (
        output address, wdata, load, store, intack,
        input  rdata, rsel, intreq, intaddress
    );

    modport slave (
        input  address, wdata, load, store, intack,
        output rdata, rsel, intreq, intaddress
    );

endinterface

// File: rtl/int_prio.sv
// Lowest-index-wins priority encoder.
//   req     : request vector, bit i is channel i
//   idx_c   : index of the lowest set bit (0 when none)
//   valid_c : at least one request present
module int_prio
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 5,
    parameter int unsigned SEL_W   = sel_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [SEL_W-1:0]   idx_c,
    output logic               valid_c
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_c   = SEL_W'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Edge-triggered interrupt controller with flag (IF) and enable (IE)
// registers, lowest-index priority and a two-state offer/ack handshake.
//   clock4 : clock, resetn : async active-low reset
//   src    : interrupt source levels, bit i is channel i
//   bus    : CPU register access plus intreq/intaddress/intack
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned       NUM_IRQ    = 5,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0040,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = 16'h0008,
    parameter logic [ADDR_W-1:0] IF_ADDR    = IF_ADDR_DEF,
    parameter logic [ADDR_W-1:0] IE_ADDR    = IE_ADDR_DEF
) (
    input  logic               clock4,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] src,
    int_ctrl_if.slave          bus
);

    localparam int unsigned SEL_W = sel_width(NUM_IRQ);

    logic [NUM_IRQ-1:0] src_q;
    logic               primed;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] if_q, if_nxt;
    logic [NUM_IRQ-1:0] ie_q, ie_nxt;
    logic [NUM_IRQ-1:0] pend;
    logic               hit_if, hit_ie;
    logic               wr_if, wr_ie;
    logic               ack_fire;
    logic [SEL_W-1:0]   prio_idx;
    logic               prio_vld;
    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel, sel_nxt;
    logic [DATA_W-1:0]  rd_if, rd_ie;

    assign hit_if   = (bus.address == IF_ADDR);
    assign hit_ie   = (bus.address == IE_ADDR);
    assign wr_if    = bus.store && hit_if;
    assign wr_ie    = bus.store && hit_ie;
    assign ack_fire = (state == ST_OFFER) && bus.intack;
    assign pend     = if_q & ie_q;

    // primed stays low for the first clock after reset, so a source that is
    // already high at release only loads the history and never counts as an edge.
    assign rise = src & ~src_q & {NUM_IRQ{primed}};

    // Source history.
    always_ff @(posedge clock4 or negedge resetn) begin
        if (!resetn) begin
            src_q  <= '0;
            primed <= 1'b0;
        end else begin
            src_q  <= src;
            primed <= 1'b1;
        end
    end

    // IF resolution order: CPU write, then ack clear, then edge set.
    always_comb begin
        if_nxt = if_q;
        ie_nxt = ie_q;
        if (wr_if) if_nxt = bus.wdata[NUM_IRQ-1:0];
        if (wr_ie) ie_nxt = bus.wdata[NUM_IRQ-1:0];
        if (ack_fire) if_nxt[sel] = 1'b0;
        if_nxt = if_nxt | rise;
    end

    // Flag and enable registers.
    always_ff @(posedge clock4 or negedge resetn) begin
        if (!resetn) begin
            if_q <= '0;
            ie_q <= '0;
        end else begin
            if_q <= if_nxt;
            ie_q <= ie_nxt;
        end
    end

    int_prio #(
        .NUM_IRQ (NUM_IRQ),
        .SEL_W   (SEL_W)
    ) u_prio (
        .req     (pend),
        .idx_c   (prio_idx),
        .valid_c (prio_vld)
    );

    // FSM state register; sel is latched only on entry to OFFER.
    always_ff @(posedge clock4 or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    // FSM next state; OFFER leaves on ack or when the offered channel is
    // no longer both flagged and enabled after this cycle's updates.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        case (state)
            ST_IDLE: begin
                if (prio_vld) begin
                    state_nxt = ST_OFFER;
                    sel_nxt   = prio_idx;
                end
            end
            ST_OFFER: begin
                if (ack_fire || !(if_nxt[sel] && ie_nxt[sel])) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from registered state only.
    always_comb begin
        bus.intreq     = 1'b0;
        bus.intaddress = '0;
        if (state == ST_OFFER) begin
            bus.intreq     = 1'b1;
            bus.intaddress = VEC_BASE + ADDR_W'(sel) * VEC_STRIDE;
        end
    end

    // Register readback; unimplemented high bits read as 1.
    always_comb begin
        rd_if                = '1;
        rd_ie                = '1;
        rd_if[NUM_IRQ-1:0]   = if_q;
        rd_ie[NUM_IRQ-1:0]   = ie_q;
        bus.rsel             = bus.load && (hit_if || hit_ie);
        bus.rdata            = '1;
        if (bus.load && hit_if) begin
            bus.rdata = rd_if;
        end else if (bus.load && hit_ie) begin
            bus.rdata = rd_ie;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl: a default instance and an
// 8-channel instance with a wrapping vector base.
module tb_int_ctrl;

    localparam logic [15:0] A_IF = 16'hff0f;
    localparam logic [15:0] A_IE = 16'hffff;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] src0;
    logic [7:0] src1;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] d;

    int_ctrl_if bus0 ();
    int_ctrl_if bus1 ();

    int_ctrl u0 (
        .clock4 (clk),
        .resetn (resetn),
        .src    (src0),
        .bus    (bus0)
    );

    int_ctrl #(
        .NUM_IRQ    (8),
        .VEC_BASE   (16'hfff0),
        .VEC_STRIDE (16'h0004)
    ) u1 (
        .clock4 (clk),
        .resetn (resetn),
        .src    (src1),
        .bus    (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd0(input logic [15:0] a, output logic [7:0] v);
        bus0.load    = 1'b1;
        bus0.address = a;
        #1;
        v            = bus0.rdata;
        bus0.load    = 1'b0;
        bus0.address = 16'h0000;
    endtask

    task automatic wr0(input logic [15:0] a, input logic [7:0] v);
        bus0.store   = 1'b1;
        bus0.address = a;
        bus0.wdata   = v;
        tick();
        bus0.store   = 1'b0;
        bus0.address = 16'h0000;
        bus0.wdata   = 8'h00;
    endtask

    task automatic ack0();
        bus0.intack = 1'b1;
        tick();
        bus0.intack = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        src0 = '0;
        src1 = '0;
        bus0.address = '0; bus0.wdata = '0; bus0.load = 1'b0; bus0.store = 1'b0; bus0.intack = 1'b0;
        bus1.address = '0; bus1.wdata = '0; bus1.load = 1'b0; bus1.store = 1'b0; bus1.intack = 1'b0;
        #12;

        // Reset state
        check("rst_intreq", 16'(bus0.intreq), 16'h0);
        check("rst_intaddr", bus0.intaddress, 16'h0000);
        rd0(A_IF, d);
        check("rst_if", 16'(d), 16'h00e0);
        bus0.load = 1'b1; bus0.address = A_IE; #1;
        check("rsel_hit", 16'(bus0.rsel), 16'h1);
        bus0.address = 16'h1234; #1;
        check("rsel_miss", 16'(bus0.rsel), 16'h0);
        check("rdata_miss", 16'(bus0.rdata), 16'h00ff);
        bus0.load = 1'b0; bus0.address = 16'h0000;

        @(posedge clk); #1;
        resetn = 1'b1;
        tick(); tick();

        // Single channel: edge on src[2]
        wr0(A_IE, 8'h1f);
        rd0(A_IE, d);
        check("ie_read", 16'(d), 16'h00ff);
        src0[2] = 1'b1;
        tick();
        rd0(A_IF, d);
        check("if_ch2", 16'(d), 16'h00e4);
        tick();
        check("offer2_req", 16'(bus0.intreq), 16'h1);
        check("offer2_addr", bus0.intaddress, 16'h0050);
        ack0();
        rd0(A_IF, d);
        check("if_after_ack", 16'(d), 16'h00e0);
        check("req_after_ack", 16'(bus0.intreq), 16'h0);
        tick(); tick();
        check("held_src_no_reset", 16'(bus0.intreq), 16'h0);
        src0 = '0;
        tick();

        // Frozen offer: src[4] then src[0]
        src0[4] = 1'b1;
        tick();
        src0[0] = 1'b1;
        tick();
        check("offer4_addr", bus0.intaddress, 16'h0060);
        tick();
        check("offer4_frozen", bus0.intaddress, 16'h0060);
        ack0();
        check("gap_after_ack", 16'(bus0.intreq), 16'h0);
        tick();
        check("offer0_addr", bus0.intaddress, 16'h0040);
        ack0();
        src0 = '0;
        tick(); tick();
        check("all_served", 16'(bus0.intreq), 16'h0);

        // Withdraw on IE clear
        src0[1] = 1'b1;
        tick(); tick();
        check("offer1_addr", bus0.intaddress, 16'h0048);
        wr0(A_IE, 8'h00);
        check("withdraw_req", 16'(bus0.intreq), 16'h0);
        check("withdraw_addr", bus0.intaddress, 16'h0000);
        rd0(A_IF, d);
        check("withdraw_if", 16'(d), 16'h00e2);

        // Ack in IDLE ignored
        wr0(A_IF, 8'h01);
        ack0();
        rd0(A_IF, d);
        check("idle_ack_ignored", 16'(d), 16'h00e1);
        wr0(A_IF, 8'h00);
        wr0(A_IE, 8'h1f);
        src0 = '0;
        tick(); tick();

        // Write + ack + edge in one cycle
        src0[0] = 1'b1;
        tick(); tick();
        check("offer0b_addr", bus0.intaddress, 16'h0040);
        bus0.store = 1'b1; bus0.address = A_IF; bus0.wdata = 8'h01;
        bus0.intack = 1'b1;
        src0[1] = 1'b1;
        tick();
        bus0.store = 1'b0; bus0.address = 16'h0000; bus0.wdata = 8'h00;
        bus0.intack = 1'b0;
        rd0(A_IF, d);
        check("collide_if", 16'(d), 16'h00e2);
        check("collide_req", 16'(bus0.intreq), 16'h0);
        tick();
        check("collide_reoffer", bus0.intaddress, 16'h0048);
        ack0();
        src0 = '0;
        tick(); tick();

        // 8-channel instance: vector wraps modulo 2^16
        bus1.store = 1'b1; bus1.address = A_IE; bus1.wdata = 8'h80;
        tick();
        bus1.store = 1'b0; bus1.address = 16'h0000; bus1.wdata = 8'h00;
        src1[7] = 1'b1;
        tick(); tick();
        check("wrap_req", 16'(bus1.intreq), 16'h1);
        check("wrap_addr", bus1.intaddress, 16'h000c);
        bus1.load = 1'b1; bus1.address = A_IF; #1;
        check("wrap_if", 16'(bus1.rdata), 16'h0080);
        bus1.load = 1'b0; bus1.address = 16'h0000;

        // Async reset during OFFER with src[3] held high
        src0[3] = 1'b1;
        tick(); tick();
        check("offer3_addr", bus0.intaddress, 16'h0058);
        #1;
        resetn = 1'b0;
        #1;
        check("async_rst_req", 16'(bus0.intreq), 16'h0);
        check("async_rst_addr", bus0.intaddress, 16'h0000);
        resetn = 1'b1;
        wr0(A_IE, 8'h1f);
        tick(); tick();
        check("held_after_rst_req", 16'(bus0.intreq), 16'h0);
        rd0(A_IF, d);
        check("held_after_rst_if", 16'(d), 16'h00e0);
        src0[3] = 1'b0;
        tick();
        src0[3] = 1'b1;
        tick(); tick();
        check("fresh_edge_req", 16'(bus0.intreq), 16'h1);
        check("fresh_edge_addr", bus0.intaddress, 16'h0058);
        ack0();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
